digit_rx_buffer: RTL and testbench
==================================

// Module: digit_rx_buffer
// PURPOSE
//  Receiving end of the RCC digit output interface (digit_clk/dout/dout_flag).
//  Detects each digit strobe, rejects repeats and malformed codes, and queues
//  ASCII digits in a FIFO. A host drains the FIFO with a valid/ready handshake.
//  Sits between results_conv and the host/UART side of the DTMF receiver, on the same clk.
// PARAMETERS
//  DEPTH  8  FIFO entries; must be a power of two, >= 2
//  AW     3  log2(DEPTH); pointer width
// PORTS
//  clk           in   1     system clock, rising-edge; the only clock
//  reset         in   1     synchronous, active-high; sampled on posedge clk
//  digit_clk     in   1     digit strobe from the RCC; registered in clk domain, high >= 1 cycle
//  digit_data    in   8     RCC dout: {1'b0, ascii[6:0]}; stable while digit_clk is high
//  digit_flag    in   1     RCC dout_flag; toggles once per new digit
//  enable        in   1     1 = accept digits; 0 = strobes ignored
//  rd_ready      in   1     host ready to pop
//  rd_valid      out  1     FIFO not empty
//  rd_data       out  7     ASCII at FIFO head; holds its value while rd_valid && !rd_ready
//  count         out  AW+1  entries held, 0..DEPTH
//  clear_status  in   1     1-cycle pulse; clears overflow, dup_err, fmt_err
//  overflow      out  1     sticky: a valid digit was dropped because the FIFO was full
//  dup_err       out  1     sticky: strobe arrived with digit_flag equal to the last accepted flag
//  fmt_err       out  1     sticky: strobe arrived with digit_data[7]=1
// BEHAVIOUR
//  Reset values:
//   - rd_valid=0, rd_data=0, count=0, overflow=0, dup_err=0, fmt_err=0
//   - internal: dclk_q=1 (a strobe that spans reset release is never captured), last_flag=0, state=WAIT
//  Edge detection:
//   - rise = digit_clk & ~dclk_q, where dclk_q is digit_clk delayed by one cycle
//   - on rise && enable: latch digit_data and digit_flag into hold registers; state WAIT->CHECK
//  FSM states: WAIT, CHECK, HOLD
//   - WAIT:  go to CHECK on rise && enable; otherwise stay
//   - CHECK (exactly 1 cycle), conditions in priority order:
//     - fmt: hold[7]=1 -> fmt_err<=1; no push; last_flag unchanged
//     - dup: hold_flag==last_flag -> dup_err<=1; no push
//     - full: count==DEPTH and no same-cycle pop -> overflow<=1; last_flag<=hold_flag
//     - else: push hold[6:0]; last_flag<=hold_flag
//     - next state is HOLD if digit_clk is still high, else WAIT
//   - HOLD:  stay until digit_clk=0, then WAIT; a stretched strobe yields one capture only
//  Latency: rise seen at edge t -> CHECK at t+1 -> rd_valid=1 after edge t+2 (FIFO initially empty).
//   No bypass path from the strobe to rd_data.
//  Handshake:
//   - pop occurs when rd_valid && rd_ready
//   - rd_ready while empty has no effect
//  Simultaneous push and pop:
//   - count unchanged
//   - when full, the pop frees the slot: push accepted, no overflow
//  Pointers are AW bits and wrap modulo DEPTH; count distinguishes full from empty.
//  clear_status coincident with a new error event: the set wins (flag reads 1 next cycle).
//  enable=0: strobes are discarded with no error flags and no last_flag update;
//   the FIFO still drains normally.
//  reset asserted mid-operation: FIFO contents are lost, FSM returns to WAIT,
//   all outputs take reset values at the next edge.
//  Widths: count is AW+1 bits; no arithmetic beyond pointer and count increment/decrement.
// STRUCTURE
//  Shared header dtmf_defs.h:
//   - FSM state codes (WAIT=2'd0, CHECK=2'd1, HOLD=2'd2)
//   - DIGIT_FMT_BIT=7
//   - default DEPTH
//  Sub-module digit_fifo (parameters DEPTH/AW; ports push, pop, wdata[6:0],
//   rdata, count, full, empty). Storage is a register array with a read-from-head output.
//  Top level holds edge detection, the FSM, last_flag and the status flags.
// TESTING
//  1. Reset, then strobe data=8'h35 flag=1 for 1 cycle -> rd_valid=1 two edges
//     after the rise; rd_data=7'h35; count=1.
//  2. Strobe '1' (flag=1), then '1' again with flag=1 -> dup_err=1, count=1;
//     clear_status -> dup_err=0.
//  3. Push 8 digits ('0'..'7', flag alternating) with rd_ready=0, then a 9th ('8')
//     -> overflow=1, count=8; drain -> '0'..'7' in order, then rd_valid=0.
//  4. FIFO full, 9th strobe arrives with rd_ready=1 in the CHECK cycle
//     -> no overflow, count stays 8, '8' is last out.
//  5. Strobe data=8'hB2 -> fmt_err=1, nothing pushed; next strobe '2' with flag
//     toggled relative to the last accepted flag -> accepted.
//  6. digit_clk held high for 5 cycles -> exactly one push.
//     Reset asserted during that strobe -> no push after release, all outputs 0.

Source files
------------

// File: rtl/digit_rx_buffer_pkg.sv
// rtl/digit_rx_buffer_pkg.sv - shared constants for the digit receive buffer
// Purpose: FSM state codes, digit format bit position and default FIFO depth
//          used by digit_rx_buffer and digit_fifo.
// Ports:   none (package).
package digit_rx_buffer_pkg;

   localparam logic [1:0] ST_WAIT  = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   // RCC codes carry 7-bit ASCII; bit 7 set marks a malformed code
   localparam int DIGIT_FMT_BIT = 7;

   localparam int DEFAULT_DEPTH = 8;

endpackage

// File: rtl/digit_fifo.sv
// rtl/digit_fifo.sv - register-array FIFO holding received ASCII digits
// Purpose: DEPTH-entry FIFO with read-from-head output.
// Ports:   clk, reset      - clock, synchronous active-high reset
//          push, wdata     - write request and 7-bit data
//          pop             - read request (ignored while empty)
//          rdata           - head entry, 0 while empty
//          count           - entries held, 0..DEPTH
//          full, empty     - occupancy status
module digit_fifo
   import digit_rx_buffer_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [6:0]    wdata,
   output logic [6:0]    rdata,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [6:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_COUNT);
   assign do_pop  = pop & ~empty;
   // a pop in the same cycle frees the slot, so a full FIFO can still take a push
   assign do_push = push & (~full | do_pop);
   assign rdata   = empty ? 7'd0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/digit_rx_buffer.sv
// rtl/digit_rx_buffer.sv - RCC digit strobe receiver with host-side FIFO
// Purpose: detects digit strobes, rejects repeats and malformed codes,
//          queues ASCII digits for the host.
// Ports:   clk, reset                  - clock, synchronous active-high reset
//          digit_clk/data/flag         - RCC digit interface
//          enable                      - accept strobes when 1
//          rd_ready, rd_valid, rd_data - host pop handshake
//          count                       - FIFO occupancy
//          clear_status                - clears the sticky flags
//          overflow, dup_err, fmt_err  - sticky status flags
module digit_rx_buffer
   import digit_rx_buffer_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          digit_clk,
   input  logic [7:0]    digit_data,
   input  logic          digit_flag,
   input  logic          enable,
   input  logic          rd_ready,
   output logic          rd_valid,
   output logic [6:0]    rd_data,
   output logic [AW:0]   count,
   input  logic          clear_status,
   output logic          overflow,
   output logic          dup_err,
   output logic          fmt_err
);

   logic       dclk_q;
   logic       rise;
   logic [1:0] state;
   logic [7:0] hold_data;
   logic       hold_flag;
   logic       last_flag;
   logic       fifo_full;
   logic       fifo_empty;
   logic       pop;
   logic       push;
   logic       in_check;
   logic       is_fmt;
   logic       is_dup;
   logic       accept;
   logic       is_ovf;

   assign rise     = digit_clk & ~dclk_q;
   assign pop      = rd_ready & ~fifo_empty;
   assign rd_valid = ~fifo_empty;
   assign in_check = (state == ST_CHECK);

   // format error outranks the duplicate test; a malformed code never touches last_flag
   assign is_fmt = in_check & hold_data[DIGIT_FMT_BIT];
   assign is_dup = in_check & ~hold_data[DIGIT_FMT_BIT] & (hold_flag == last_flag);
   assign accept = in_check & ~hold_data[DIGIT_FMT_BIT] & (hold_flag != last_flag);
   // a dropped digit still counts as seen, so last_flag follows accept, not push
   assign is_ovf = accept & fifo_full & ~pop;
   assign push   = accept & ~is_ovf;

   digit_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (hold_data[6:0]),
      .rdata (rd_data),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         // dclk_q starts high so a strobe already high at release is not a rise
         dclk_q    <= 1'b1;
         state     <= ST_WAIT;
         hold_data <= '0;
         hold_flag <= 1'b0;
         last_flag <= 1'b0;
         overflow  <= 1'b0;
         dup_err   <= 1'b0;
         fmt_err   <= 1'b0;
      end else begin
         dclk_q <= digit_clk;

         case (state)
            ST_WAIT: begin
               if (rise && enable) begin
                  hold_data <= digit_data;
                  hold_flag <= digit_flag;
                  state     <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               state <= digit_clk ? ST_HOLD : ST_WAIT;
            end
            ST_HOLD: begin
               if (!digit_clk) begin
                  state <= ST_WAIT;
               end
            end
            default: state <= ST_WAIT;
         endcase

         if (accept) begin
            last_flag <= hold_flag;
         end

         // a new event in the clearing cycle wins over the clear
         overflow <= is_ovf | (overflow & ~clear_status);
         dup_err  <= is_dup | (dup_err  & ~clear_status);
         fmt_err  <= is_fmt | (fmt_err  & ~clear_status);
      end
   end

endmodule

// File: tb/tb_digit_rx_buffer.sv
// tb/tb_digit_rx_buffer.sv - scoreboard bench for digit_rx_buffer
module tb_digit_rx_buffer;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          digit_clk = 1'b0;
   logic [7:0]    digit_data = 8'h00;
   logic          digit_flag = 1'b0;
   logic          enable = 1'b1;
   logic          rd_ready = 1'b0;
   logic          clear_status = 1'b0;
   logic          rd_valid;
   logic [6:0]    rd_data;
   logic [AW:0]   count;
   logic          overflow;
   logic          dup_err;
   logic          fmt_err;

   always #5 clk = ~clk;

   digit_rx_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .digit_clk    (digit_clk),
      .digit_data   (digit_data),
      .digit_flag   (digit_flag),
      .enable       (enable),
      .rd_ready     (rd_ready),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .count        (count),
      .clear_status (clear_status),
      .overflow     (overflow),
      .dup_err      (dup_err),
      .fmt_err      (fmt_err)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: FIFO content as a queue, occupancy and sticky flags
   logic [6:0] exp_q[$];
   logic [6:0] got_q[$];
   int         m_count = 0;
   bit         m_ovf = 0, m_dup = 0, m_fmt = 0, m_last = 0;
   bit         pend = 0;
   logic [7:0] pd = 8'h00;
   bit         pf = 0;
   bit         strobe_req = 0;
   logic [7:0] req_data = 8'h00;
   bit         req_flag = 0, req_en = 0;
   bit         mon_en = 0;
   bit         rand_mode = 0;
   int         ready_pct = 50;

   initial forever begin
      bit pop, push, s_o, s_d, s_f;
      @(posedge clk);
      if (reset) begin
         exp_q.delete();
         m_count = 0;
         m_ovf = 0; m_dup = 0; m_fmt = 0; m_last = 0;
         pend = 0;
      end else begin
         pop = rd_ready && (m_count > 0);
         push = 0; s_o = 0; s_d = 0; s_f = 0;
         if (pend) begin
            pend = 0;
            if (pd[7]) s_f = 1;
            else if (pf == m_last) s_d = 1;
            else begin
               m_last = pf;
               if (m_count == DEPTH && !pop) s_o = 1;
               else begin
                  push = 1;
                  exp_q.push_back(pd[6:0]);
               end
            end
         end
         if (strobe_req && req_en) begin
            pend = 1; pd = req_data; pf = req_flag;
         end
         m_ovf = s_o | (m_ovf & !clear_status);
         m_dup = s_d | (m_dup & !clear_status);
         m_fmt = s_f | (m_fmt & !clear_status);
         m_count = m_count + int'(push) - int'(pop);
      end
   end

   // monitor: compares every cycle, pops the scoreboard on each handshake
   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_count != 0});
         chk("count", 32'(count), 32'(m_count));
         chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
         chk("dup_err", {31'd0, dup_err}, {31'd0, m_dup});
         chk("fmt_err", {31'd0, fmt_err}, {31'd0, m_fmt});
         if (rd_valid) begin
            if (exp_q.size() == 0) begin
               chk("rd_data_unexpected", {31'd0, rd_valid}, 32'd0);
            end else begin
               chk("rd_data", 32'(rd_data), 32'(exp_q[0]));
               if (rd_ready) begin
                  got_q.push_back(rd_data);
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rand_mode) begin
         rd_ready = ($urandom % 100) < ready_pct;
         clear_status = ($urandom % 25) == 0;
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // strobe high for len cycles; optionally rd_ready only during the CHECK cycle
   task automatic strobe(input logic [7:0] d, input bit f, input int len, input bit ric);
      @(posedge clk); #1;
      digit_clk = 1'b1; digit_data = d; digit_flag = f;
      strobe_req = 1; req_data = d; req_flag = f; req_en = enable;
      @(posedge clk); #1;
      strobe_req = 0;
      if (ric) rd_ready = 1'b1;
      for (int i = 1; i < len; i++) begin
         @(posedge clk); #1;
         if (ric) rd_ready = 1'b0;
      end
      digit_clk = 1'b0;
      @(posedge clk); #1;
      if (ric) rd_ready = 1'b0;
   endtask

   task automatic drain(input int cycles);
      rd_ready = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      rd_ready = 1'b0;
   endtask

   task automatic fill_eight();
      for (int i = 0; i < 8; i++) begin
         strobe(8'h30 + 8'(i), (i % 2) == 0, 1, 0);
      end
   endtask

   initial begin
      bit tb_flag;
      do_reset();
      mon_en = 1;
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_flags", {29'd0, overflow, dup_err, fmt_err}, 32'd0);

      // 1: latency of a single strobe
      @(posedge clk); #1;
      digit_clk = 1'b1; digit_data = 8'h35; digit_flag = 1'b1;
      strobe_req = 1; req_data = 8'h35; req_flag = 1; req_en = 1;
      @(posedge clk); #1;
      strobe_req = 0; digit_clk = 1'b0;
      chk("t1_valid_edge1", {31'd0, rd_valid}, 32'd0);
      @(posedge clk); #1;
      chk("t1_valid_edge2", {31'd0, rd_valid}, 32'd1);
      chk("t1_data", 32'(rd_data), 32'h35);
      chk("t1_count", 32'(count), 32'd1);

      // 2: duplicate flag, then clear_status
      do_reset();
      strobe(8'h31, 1, 1, 0);
      strobe(8'h31, 1, 1, 0);
      chk("t2_dup", {31'd0, dup_err}, 32'd1);
      chk("t2_count", 32'(count), 32'd1);
      clear_status = 1'b1;
      @(posedge clk); #1;
      clear_status = 1'b0;
      chk("t2_dup_cleared", {31'd0, dup_err}, 32'd0);

      // 3: overflow on the ninth digit, then in-order drain
      do_reset();
      fill_eight();
      strobe(8'h38, 1, 1, 0);
      chk("t3_overflow", {31'd0, overflow}, 32'd1);
      chk("t3_count", 32'(count), 32'd8);
      got_q.delete();
      drain(10);
      chk("t3_drained", 32'(got_q.size()), 32'd8);
      for (int i = 0; i < 8 && i < got_q.size(); i++)
         chk("t3_order", 32'(got_q[i]), 32'h30 + 32'(i));
      chk("t3_empty", {31'd0, rd_valid}, 32'd0);

      // 4: full FIFO, pop in the CHECK cycle makes room
      do_reset();
      fill_eight();
      got_q.delete();
      strobe(8'h38, 1, 1, 1);
      chk("t4_overflow", {31'd0, overflow}, 32'd0);
      chk("t4_count", 32'(count), 32'd8);
      drain(10);
      chk("t4_drained", 32'(got_q.size()), 32'd9);
      if (got_q.size() == 9) chk("t4_last", 32'(got_q[8]), 32'h38);

      // 5: malformed code leaves last_flag alone
      do_reset();
      strobe(8'hB2, 1, 1, 0);
      chk("t5_fmt", {31'd0, fmt_err}, 32'd1);
      chk("t5_count0", 32'(count), 32'd0);
      strobe(8'h32, 1, 1, 0);
      chk("t5_count1", 32'(count), 32'd1);
      chk("t5_data", 32'(rd_data), 32'h32);

      // enable low: no capture, no flags
      enable = 1'b0;
      strobe(8'hB3, 0, 1, 0);
      strobe(8'h33, 1, 1, 0);
      enable = 1'b1;
      chk("en0_count", 32'(count), 32'd1);
      chk("en0_fmt_still", {31'd0, fmt_err}, 32'd1);
      chk("en0_dup", {31'd0, dup_err}, 32'd0);

      // 6: stretched strobe gives one push; reset during a strobe loses all
      do_reset();
      strobe(8'h34, 1, 5, 0);
      chk("t6_one_push", 32'(count), 32'd1);
      @(posedge clk); #1;
      digit_clk = 1'b1; digit_data = 8'h35; digit_flag = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      digit_clk = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t6_count", 32'(count), 32'd0);
      chk("t6_valid", {31'd0, rd_valid}, 32'd0);
      chk("t6_data", 32'(rd_data), 32'd0);
      chk("t6_flags", {29'd0, overflow, dup_err, fmt_err}, 32'd0);

      // random traffic against the model
      do_reset();
      tb_flag = 0;
      rand_mode = 1;
      for (int n = 0; n < 300; n++) begin
         logic [7:0] d;
         bit f;
         ready_pct = (n < 150) ? 10 : 70;
         if (($urandom % 10) == 0) d = {1'b1, 7'($urandom)};
         else d = {1'b0, 7'($urandom_range(32, 126))};
         f = (($urandom % 4) == 0) ? tb_flag : !tb_flag;
         tb_flag = f;
         enable = ($urandom % 10) != 0;
         strobe(d, f, $urandom_range(1, 4), 0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      enable = 1'b1;
      rand_mode = 0;
      @(posedge clk); #1;
      clear_status = 1'b0;
      drain(12);
      chk("rand_empty", {31'd0, rd_valid}, 32'd0);
      chk("rand_scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
